// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, stall vectors and
// register-address helpers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_LU   = 2'd1,
        HZ_EXW  = 2'd2,
        HZ_MEMW = 2'd3
    } hz_state_e;

    localparam int unsigned StallW = 6;

    // Hold bits are {wb, mem, ex, id, if, pc}; bit 0 is the PC.
    localparam logic [StallW-1:0] STALL_NONE = 6'b000000;
    localparam logic [StallW-1:0] STALL_LU   = 6'b000111;
    localparam logic [StallW-1:0] STALL_EX   = 6'b001111;
    localparam logic [StallW-1:0] STALL_MEM  = 6'b011111;

    localparam logic RstEnable = 1'b1;

    localparam int unsigned RegAddrBus = 5;
    typedef logic [RegAddrBus-1:0] reg_addr_t;
    localparam reg_addr_t NOPRegAddr = '0;

    function automatic logic src_match(input logic rd, input reg_addr_t ra, input reg_addr_t wd);
        return rd && (ra == wd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over inc.
module sat_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use detection, EX/MEM stall arbitration, branch
// flushes (deferred across memory waits), stall/flush statistics and an EX-stall watchdog.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_read_i,
    input  logic                  id_reg2_read_i,
    input  logic [RegAddrBus-1:0] id_reg1_addr_i,
    input  logic [RegAddrBus-1:0] id_reg2_addr_i,
    input  logic                  ex_wreg_i,
    input  logic [RegAddrBus-1:0] ex_wd_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_stallreq_i,
    input  logic                  mem_stallreq_i,
    input  logic                  branch_flush_i,
    output logic [StallW-1:0]     stall_o,
    output logic                  flush_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  timeout_o
);

    localparam int unsigned RunW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [RunW-1:0] RunLast = RunW'(STALL_TIMEOUT - 1);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      pending_q;
    logic      pending_d;
    logic      timeout_q;
    logic      timeout_d;

    logic [StallW-1:0] stall;
    logic              flush;
    logic              lu_hit;
    logic              ex_load_wr;
    logic              src_hit;
    logic [RunW-1:0]   ex_run;

    // A load targeting x0 never creates a dependency.
    assign ex_load_wr = ex_is_load_i && ex_wreg_i && (ex_wd_i != NOPRegAddr);
    assign src_hit    = src_match(id_reg1_read_i, id_reg1_addr_i, ex_wd_i) ||
                        src_match(id_reg2_read_i, id_reg2_addr_i, ex_wd_i);
    // Suppressing while in LU bounds the load-use bubble to one cycle.
    assign lu_hit     = ex_load_wr && src_hit && (state_q != HZ_LU);

    always_comb begin
        stall     = STALL_NONE;
        flush     = 1'b0;
        state_d   = HZ_RUN;
        pending_d = pending_q;
        if (rst == RstEnable) begin
            pending_d = 1'b0;
        end else if (mem_stallreq_i) begin
            stall   = STALL_MEM;
            state_d = HZ_MEMW;
            // The branch cannot flush while MEM holds the pipe; replay it once MEM releases.
            if (branch_flush_i) begin
                pending_d = 1'b1;
            end
        end else if (branch_flush_i || pending_q) begin
            flush     = 1'b1;
            pending_d = 1'b0;
        end else if (ex_stallreq_i) begin
            stall   = STALL_EX;
            state_d = HZ_EXW;
        end else if (lu_hit) begin
            stall   = STALL_LU;
            state_d = HZ_LU;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if ((state_d == HZ_EXW) && (ex_run >= RunLast)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= HZ_RUN;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall[0]),
        .clear (1'b0),
        .count (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .clear (1'b0),
        .count (flush_cnt_o)
    );

    sat_counter #(
        .WIDTH (RunW)
    ) u_ex_run (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_d == HZ_EXW),
        .clear (state_d != HZ_EXW),
        .count (ex_run)
    );

    assign stall_o   = stall;
    assign flush_o   = flush;
    assign state_o   = state_q;
    assign timeout_o = timeout_q;

endmodule
